mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arb_grant.sv | 51 +++++
 rtl/mem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the I/D cache memory arbiter slice.
//   - BLK_ADDR_W_DEF / BLK_DATA_W_DEF : default widths of a 16-byte block
//     address and of one cache block.
//   - arb_state_t : arbiter FSM states (2-bit encoding).
//   - arb_side_t  : identifies a requester side (used by the optional
//     round-robin pointer enabled with MEM_ARB_RR_EN).
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int BLK_ADDR_W_DEF = 28;
  localparam int BLK_DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_D = 2'd1,
    SERVE_I = 2'd2
  } arb_state_t;

  typedef enum logic {
    SIDE_D = 1'b0,
    SIDE_I = 1'b1
  } arb_side_t;

endpackage

// File: rtl/mem_arb_grant.sv
// ---------------------------------------------------------------------------
// mem_arb_grant
// Purely combinational grant select between the D-cache and I-cache
// requesters. Only one grant is ever asserted.
//
// Build option:
//   MEM_ARB_RR_EN undefined : a contested request always goes to D.
//   MEM_ARB_RR_EN defined   : a contested request goes to the side named by
//                             rr_ptr (the least recently favoured side).
//
// Ports:
//   d_req   in  1  D-cache request pending (read or write-back)
//   i_req   in  1  I-cache request pending
//   rr_ptr  in  1  favoured side on contention (MEM_ARB_RR_EN builds only)
//   grant_d out 1  D side wins this cycle
//   grant_i out 1  I side wins this cycle
// ---------------------------------------------------------------------------
module mem_arb_grant
  import mem_arbiter_pkg::*;
(
  input  logic      d_req,
  input  logic      i_req,
`ifdef MEM_ARB_RR_EN
  input  arb_side_t rr_ptr,
`endif
  output logic      grant_d,
  output logic      grant_i
);

  // An uncontested request is granted directly; only the case where both
  // sides ask in the same cycle needs a tie-break.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (d_req && i_req) begin
`ifdef MEM_ARB_RR_EN
      if (rr_ptr == SIDE_I) begin
        grant_i = 1'b1;
      end else begin
        grant_d = 1'b1;
      end
`else
      grant_d = 1'b1;
`endif
    end else begin
      grant_d = d_req;
      grant_i = i_req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one block-wide main-memory port between a read-only I-cache and a
// read/write-back D-cache. A request seen in IDLE is latched into the
// registered MEM_* port, held stable for the whole transaction, and
// completes on the first cycle after memory has raised and then dropped
// MEM_BUSYWAIT. Reset is synchronous and active-high.
//
// Build option: MEM_ARB_RR_EN -- when defined, contested requests are
// granted to the side held in a round-robin pointer instead of always to D.
//
// Ports:
//   CLK, RESET                  clock / synchronous active-high reset
//   I_READ, I_ADDRESS           I-cache fill request and block address
//   I_READDATA, I_BUSYWAIT      block returned to the I-cache, I stall
//   D_READ, D_WRITE             D-cache fill / write-back request
//   D_ADDRESS, D_WRITEDATA      D-cache block address and write-back block
//   D_READDATA, D_BUSYWAIT      block returned to the D-cache, D stall
//   MEM_READ, MEM_WRITE         registered memory operation strobes
//   MEM_ADDRESS, MEM_WRITEDATA  registered memory address / write block
//   MEM_READDATA, MEM_BUSYWAIT  memory response block and busy flag
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BLK_ADDR_W = BLK_ADDR_W_DEF,
  parameter int BLK_DATA_W = BLK_DATA_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  I_READ,
  input  logic [BLK_ADDR_W-1:0] I_ADDRESS,
  output logic [BLK_DATA_W-1:0] I_READDATA,
  output logic                  I_BUSYWAIT,
  input  logic                  D_READ,
  input  logic                  D_WRITE,
  input  logic [BLK_ADDR_W-1:0] D_ADDRESS,
  input  logic [BLK_DATA_W-1:0] D_WRITEDATA,
  output logic [BLK_DATA_W-1:0] D_READDATA,
  output logic                  D_BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [BLK_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLK_DATA_W-1:0] MEM_WRITEDATA,
  input  logic [BLK_DATA_W-1:0] MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  arb_state_t            state;
  arb_state_t            state_next;
  logic                  started;
  logic                  d_req;
  logic                  i_req;
  logic                  grant_d;
  logic                  grant_i;
  logic                  mem_done;
  logic                  complete_d;
  logic                  complete_i;
  logic                  d_deliver;
  logic                  i_deliver;
  logic [BLK_DATA_W-1:0] d_rd_q;
  logic [BLK_DATA_W-1:0] i_rd_q;

  assign d_req = D_READ | D_WRITE;
  assign i_req = I_READ;

  // A transaction is finished once memory has shown busy at least once and
  // has now dropped busy. Gating with RESET keeps the reset cycle from
  // looking like a completion to the requesters.
  assign mem_done   = started & ~MEM_BUSYWAIT & ~RESET;
  assign complete_d = (state == SERVE_D) & mem_done;
  assign complete_i = (state == SERVE_I) & mem_done;

  // Returned data is only handed over for a read whose requester is still
  // asking; a write-back, or a request withdrawn mid-transaction, leaves the
  // held value untouched.
  assign d_deliver = complete_d & MEM_READ & D_READ;
  assign i_deliver = complete_i & I_READ;

  assign D_BUSYWAIT = ~RESET & d_req & ~complete_d;
  assign I_BUSYWAIT = ~RESET & i_req & ~complete_i;

  assign D_READDATA = d_deliver ? MEM_READDATA : d_rd_q;
  assign I_READDATA = i_deliver ? MEM_READDATA : i_rd_q;

`ifdef MEM_ARB_RR_EN
  arb_side_t rr_ptr;

  // The pointer only moves when a completion leaves the other side waiting,
  // so a side that was made to wait is favoured at the next contention.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rr_ptr <= SIDE_D;
    end else if (complete_d && i_req) begin
      rr_ptr <= SIDE_I;
    end else if (complete_i && d_req) begin
      rr_ptr <= SIDE_D;
    end
  end

  mem_arb_grant u_grant (
    .d_req   (d_req),
    .i_req   (i_req),
    .rr_ptr  (rr_ptr),
    .grant_d (grant_d),
    .grant_i (grant_i)
  );
`else
  mem_arb_grant u_grant (
    .d_req   (d_req),
    .i_req   (i_req),
    .grant_d (grant_d),
    .grant_i (grant_i)
  );
`endif

  // Next-state logic: grant from IDLE, return to IDLE on completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_next = SERVE_D;
        end else if (grant_i) begin
          state_next = SERVE_I;
        end
      end
      SERVE_D: begin
        if (complete_d) begin
          state_next = IDLE;
        end
      end
      SERVE_I: begin
        if (complete_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus the registered memory port. The winner's request is
  // captured once in IDLE and then left alone, so requester-side changes
  // during SERVE cannot disturb the memory transaction. Reset abandons any
  // transaction in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      started       <= 1'b0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          started <= 1'b0;
          if (grant_d) begin
            MEM_ADDRESS   <= D_ADDRESS;
            MEM_WRITEDATA <= D_WRITEDATA;
            MEM_READ      <= D_READ;
            MEM_WRITE     <= D_WRITE;
          end else if (grant_i) begin
            MEM_ADDRESS   <= I_ADDRESS;
            MEM_WRITEDATA <= '0;
            MEM_READ      <= 1'b1;
            MEM_WRITE     <= 1'b0;
          end
        end
        SERVE_D, SERVE_I: begin
          if (mem_done) begin
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            started   <= 1'b0;
          end else if (MEM_BUSYWAIT) begin
            started <= 1'b1;
          end
        end
        default: begin
          started   <= 1'b0;
          MEM_READ  <= 1'b0;
          MEM_WRITE <= 1'b0;
        end
      endcase
    end
  end

  // Holding registers for the last block delivered to each cache.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      d_rd_q <= '0;
      i_rd_q <= '0;
    end else begin
      if (d_deliver) begin
        d_rd_q <= MEM_READDATA;
      end
      if (i_deliver) begin
        i_rd_q <= MEM_READDATA;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. A small behavioural memory holds
// MEM_BUSYWAIT high for mem_lat cycles from the first cycle an operation is
// presented, and returns either a fixed pattern or a block derived from
// MEM_ADDRESS. Cycle 0 is the cycle in which a request is raised; outputs
// are sampled on the falling edge. Expected grant order on contention
// follows MEM_ARB_RR_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          CLK;
  logic          RESET;
  logic          I_READ;
  logic [AW-1:0] I_ADDRESS;
  logic [DW-1:0] I_READDATA;
  logic          I_BUSYWAIT;
  logic          D_READ;
  logic          D_WRITE;
  logic [AW-1:0] D_ADDRESS;
  logic [DW-1:0] D_WRITEDATA;
  logic [DW-1:0] D_READDATA;
  logic          D_BUSYWAIT;
  logic          MEM_READ;
  logic          MEM_WRITE;
  logic [AW-1:0] MEM_ADDRESS;
  logic [DW-1:0] MEM_WRITEDATA;
  logic [DW-1:0] MEM_READDATA;
  logic          MEM_BUSYWAIT;

  int            tests_run;
  int            tests_failed;

  int            mem_lat;
  int            mem_cnt;
  logic          addr_data;
  logic [DW-1:0] mem_pattern;

  mem_arbiter #(.BLK_ADDR_W(AW), .BLK_DATA_W(DW)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .I_READ        (I_READ),
    .I_ADDRESS     (I_ADDRESS),
    .I_READDATA    (I_READDATA),
    .I_BUSYWAIT    (I_BUSYWAIT),
    .D_READ        (D_READ),
    .D_WRITE       (D_WRITE),
    .D_ADDRESS     (D_ADDRESS),
    .D_WRITEDATA   (D_WRITEDATA),
    .D_READDATA    (D_READDATA),
    .D_BUSYWAIT    (D_BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  // 100 MHz clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural memory: counts cycles an operation has been presented and
  // reports busy for the first mem_lat of them.
  always @(posedge CLK) begin
    if (!(MEM_READ || MEM_WRITE)) begin
      mem_cnt <= 0;
    end else begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < mem_lat);
  assign MEM_READDATA = addr_data ? {4{4'h0, MEM_ADDRESS}} : mem_pattern;

  // Bounds the whole run in case the design wedges somewhere unexpected.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, tests_failed=%0d", tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    D_READ = 1'b1;
    I_READ = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    tests_run++;
    if (D_BUSYWAIT !== 1'b0 || I_BUSYWAIT !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_busywait: got D=%b I=%b expected 0 0", D_BUSYWAIT, I_BUSYWAIT);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    tests_run++;
    if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0 || MEM_ADDRESS !== '0 || MEM_WRITEDATA !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mem_port: got rd=%b wr=%b addr=%h wdata=%h expected all 0",
               MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA);
    end
    tests_run++;
    if (D_READDATA !== '0 || I_READDATA !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_readdata: got D=%h I=%h expected 0", D_READDATA, I_READDATA);
    end
    D_READ = 1'b0;
    I_READ = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
  endtask

  // Single I-cache fill against a 4-cycle busy memory.
  task automatic test_i_read();
    logic done;
    mem_lat = 4;
    addr_data = 1'b0;
    mem_pattern = {16{8'hA5}};
    done = 1'b0;
    I_ADDRESS = 28'h0000010;
    I_READ = 1'b1;
    @(negedge CLK);
    tests_run++;
    if (I_BUSYWAIT !== 1'b1 || MEM_READ !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL iread_c0: got busy=%b mem_read=%b expected 1 0", I_BUSYWAIT, MEM_READ);
    end
    for (int c = 1; c <= 6; c++) begin
      @(posedge CLK); #1;
      if (done) I_READ = 1'b0;
      if (c == 6) mem_pattern = '0;
      @(negedge CLK);
      if (c == 1) begin
        tests_run++;
        if (MEM_READ !== 1'b1 || MEM_WRITE !== 1'b0 || MEM_ADDRESS !== 28'h0000010) begin
          tests_failed++;
          $display("[TB] FAIL iread_c1_grant: got rd=%b wr=%b addr=%h expected 1 0 0000010",
                   MEM_READ, MEM_WRITE, MEM_ADDRESS);
        end
      end
      if (c >= 1 && c <= 4) begin
        tests_run++;
        if (I_BUSYWAIT !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL iread_stall_c%0d: got %b expected 1", c, I_BUSYWAIT);
        end
      end
      if (c == 5) begin
        tests_run++;
        if (I_BUSYWAIT !== 1'b0 || I_READDATA !== {16{8'hA5}}) begin
          tests_failed++;
          $display("[TB] FAIL iread_c5_complete: got busy=%b data=%h expected 0 a5..a5",
                   I_BUSYWAIT, I_READDATA);
        end
        done = 1'b1;
      end
      if (c == 6) begin
        tests_run++;
        if (MEM_READ !== 1'b0 || I_BUSYWAIT !== 1'b0 || I_READDATA !== {16{8'hA5}}) begin
          tests_failed++;
          $display("[TB] FAIL iread_c6_idle: got rd=%b busy=%b data=%h expected 0 0 a5..a5",
                   MEM_READ, I_BUSYWAIT, I_READDATA);
        end
      end
    end
    @(posedge CLK); #1;
  endtask

  // Raises D_READ (0x30) and I_READ (0x40) together and plays both
  // requesters until each has completed; reports what it observed.
  task automatic run_dual(output logic [AW-1:0] g0, output logic [AW-1:0] g1,
                          output int d_done, output int i_done, output int i_grant,
                          output logic [DW-1:0] d_data, output logic [DW-1:0] i_data,
                          output logic i_bw_ok, output logic timed_out);
    int   ngrant;
    logic prev_op;
    logic d_drop;
    logic i_drop;
    mem_lat = 2;
    addr_data = 1'b1;
    ngrant = 0;
    prev_op = 1'b0;
    d_drop = 1'b0;
    i_drop = 1'b0;
    g0 = '0;
    g1 = '0;
    d_done = -1;
    i_done = -1;
    i_grant = -1;
    d_data = '0;
    i_data = '0;
    i_bw_ok = 1'b1;
    D_ADDRESS = 28'h0000030;
    I_ADDRESS = 28'h0000040;
    D_READ = 1'b1;
    I_READ = 1'b1;
    for (int c = 0; c < 60 && (D_READ || I_READ); c++) begin
      if (c > 0) begin
        @(posedge CLK); #1;
        if (d_drop) D_READ = 1'b0;
        if (i_drop) I_READ = 1'b0;
      end
      @(negedge CLK);
      if (MEM_READ && !prev_op) begin
        if (ngrant == 0) g0 = MEM_ADDRESS;
        else if (ngrant == 1) g1 = MEM_ADDRESS;
        if (MEM_ADDRESS == 28'h0000040) i_grant = c;
        ngrant++;
      end
      prev_op = MEM_READ;
      if (d_done < 0 && I_READ && !I_BUSYWAIT && D_READ) i_bw_ok = 1'b0;
      if (D_READ && !D_BUSYWAIT && !d_drop) begin
        d_done = c;
        d_data = D_READDATA;
        d_drop = 1'b1;
      end
      if (I_READ && !I_BUSYWAIT && !i_drop) begin
        i_done = c;
        i_data = I_READDATA;
        i_drop = 1'b1;
      end
    end
    timed_out = D_READ || I_READ;
    D_READ = 1'b0;
    I_READ = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_priority();
    logic [AW-1:0] g0, g1;
    int            d_done, i_done, i_grant;
    logic [DW-1:0] d_data, i_data;
    logic          i_bw_ok, timed_out;
    run_dual(g0, g1, d_done, i_done, i_grant, d_data, i_data, i_bw_ok, timed_out);
    tests_run++;
    if (timed_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL prio_timeout: got timed_out=%b expected 0", timed_out);
    end
    tests_run++;
    if (g0 !== 28'h0000030 || g1 !== 28'h0000040) begin
      tests_failed++;
      $display("[TB] FAIL prio_order: got %h,%h expected 0000030,0000040", g0, g1);
    end
    tests_run++;
    if (d_done != 3 || i_grant != 5 || i_done != 7) begin
      tests_failed++;
      $display("[TB] FAIL prio_timing: got d_done=%0d i_grant=%0d i_done=%0d expected 3 5 7",
               d_done, i_grant, i_done);
    end
    tests_run++;
    if (i_bw_ok !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL prio_i_stall: got I_BUSYWAIT low while D served, expected high");
    end
    tests_run++;
    if (d_data !== {4{32'h00000030}} || i_data !== {4{32'h00000040}}) begin
      tests_failed++;
      $display("[TB] FAIL prio_data: got D=%h I=%h expected 30-pattern 40-pattern", d_data, i_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] g0, g1, h0, h1;
    logic [AW-1:0] exp_h0, exp_h1;
    int            d_done, i_done, i_grant;
    logic [DW-1:0] d_data, i_data;
    logic          i_bw_ok, to1, to2;
`ifdef MEM_ARB_RR_EN
    exp_h0 = 28'h0000040;
    exp_h1 = 28'h0000030;
`else
    exp_h0 = 28'h0000030;
    exp_h1 = 28'h0000040;
`endif
    do_reset();
    run_dual(g0, g1, d_done, i_done, i_grant, d_data, i_data, i_bw_ok, to1);
    run_dual(h0, h1, d_done, i_done, i_grant, d_data, i_data, i_bw_ok, to2);
    tests_run++;
    if (to1 !== 1'b0 || to2 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_timeout: got %b %b expected 0 0", to1, to2);
    end
    tests_run++;
    if (g0 !== 28'h0000030 || g1 !== 28'h0000040 || h0 !== exp_h0 || h1 !== exp_h1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_order: got %h,%h,%h,%h expected 0000030,0000040,%h,%h",
               g0, g1, h0, h1, exp_h0, exp_h1);
    end
    tests_run++;
    if (d_data !== {4{32'h00000030}} || i_data !== {4{32'h00000040}}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_data: got D=%h I=%h expected 30-pattern 40-pattern", d_data, i_data);
    end
  endtask

  // Write-back; requester inputs are disturbed mid-transaction.
  task automatic test_write();
    logic [DW-1:0] wd;
    logic          done;
    logic          finished;
    int            done_c;
    wd = 128'h11223344_55667788_99AABBCC_DDEEEEFF;
    mem_lat = 3;
    addr_data = 1'b0;
    mem_pattern = {16{8'h3C}};
    done = 1'b0;
    finished = 1'b0;
    done_c = -1;
    D_ADDRESS = 28'h0000020;
    D_WRITEDATA = wd;
    D_WRITE = 1'b1;
    for (int c = 1; c <= 20 && !finished; c++) begin
      @(posedge CLK); #1;
      if (done) begin
        D_WRITE = 1'b0;
        finished = 1'b1;
      end
      if (c == 2) begin
        D_WRITEDATA = ~wd;
        D_ADDRESS = 28'h0000099;
      end
      @(negedge CLK);
      if (!done) begin
        tests_run++;
        if (MEM_WRITE !== 1'b1 || MEM_READ !== 1'b0 || MEM_WRITEDATA !== wd ||
            MEM_ADDRESS !== 28'h0000020) begin
          tests_failed++;
          $display("[TB] FAIL write_hold_c%0d: got wr=%b rd=%b addr=%h wdata=%h expected 1 0 0000020 %h",
                   c, MEM_WRITE, MEM_READ, MEM_ADDRESS, MEM_WRITEDATA, wd);
        end
        if (!D_BUSYWAIT) begin
          done = 1'b1;
          done_c = c;
        end
      end
      tests_run++;
      if (D_READDATA !== {4{32'h00000030}}) begin
        tests_failed++;
        $display("[TB] FAIL write_readdata_c%0d: got %h expected 30-pattern", c, D_READDATA);
      end
    end
    tests_run++;
    if (done_c != 4 || MEM_WRITE !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL write_complete: got cycle=%0d mem_write_after=%b expected 4 0", done_c, MEM_WRITE);
    end
    D_WRITE = 1'b0;
    @(posedge CLK); #1;
  endtask

  // D read whose address input moves during the transaction.
  task automatic test_addr_hold();
    logic done;
    logic finished;
    int   done_c;
    mem_lat = 3;
    addr_data = 1'b1;
    done = 1'b0;
    finished = 1'b0;
    done_c = -1;
    D_ADDRESS = 28'h0000050;
    D_READ = 1'b1;
    for (int c = 1; c <= 20 && !finished; c++) begin
      @(posedge CLK); #1;
      if (done) begin
        D_READ = 1'b0;
        finished = 1'b1;
      end
      if (c == 2) D_ADDRESS = 28'h0000060;
      @(negedge CLK);
      if (!done) begin
        tests_run++;
        if (MEM_ADDRESS !== 28'h0000050) begin
          tests_failed++;
          $display("[TB] FAIL addr_hold_c%0d: got %h expected 0000050", c, MEM_ADDRESS);
        end
        if (!D_BUSYWAIT) begin
          done = 1'b1;
          done_c = c;
          tests_run++;
          if (D_READDATA !== {4{32'h00000050}}) begin
            tests_failed++;
            $display("[TB] FAIL addr_hold_data: got %h expected 50-pattern", D_READDATA);
          end
        end
      end
    end
    tests_run++;
    if (done_c != 4) begin
      tests_failed++;
      $display("[TB] FAIL addr_hold_latency: got %0d expected 4", done_c);
    end
    @(posedge CLK); #1;
  endtask

  // Reset pulsed on the second SERVE_D cycle of a long read.
  task automatic test_reset_mid();
    mem_lat = 6;
    addr_data = 1'b1;
    D_ADDRESS = 28'h0000070;
    D_READ = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge CLK); #1;
      if (c == 2) begin
        RESET = 1'b1;
        I_ADDRESS = 28'h0000080;
        I_READ = 1'b1;
      end
      if (c == 3) begin
        RESET = 1'b0;
        D_READ = 1'b0;
        I_READ = 1'b0;
      end
      @(negedge CLK);
      if (c == 1) begin
        tests_run++;
        if (MEM_READ !== 1'b1 || D_BUSYWAIT !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL rstmid_c1: got rd=%b busy=%b expected 1 1", MEM_READ, D_BUSYWAIT);
        end
      end
      if (c == 2) begin
        tests_run++;
        if (D_BUSYWAIT !== 1'b0 || I_BUSYWAIT !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL rstmid_busywait: got D=%b I=%b expected 0 0", D_BUSYWAIT, I_BUSYWAIT);
        end
      end
      if (c == 3) begin
        tests_run++;
        if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0 || MEM_ADDRESS !== '0 || MEM_WRITEDATA !== '0 ||
            D_READDATA !== '0 || I_READDATA !== '0) begin
          tests_failed++;
          $display("[TB] FAIL rstmid_outputs: got rd=%b wr=%b addr=%h wdata=%h drd=%h ird=%h expected all 0",
                   MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, D_READDATA, I_READDATA);
        end
      end
      if (c == 4) begin
        tests_run++;
        if (MEM_READ !== 1'b0 || D_BUSYWAIT !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL rstmid_idle: got rd=%b busy=%b expected 0 0", MEM_READ, D_BUSYWAIT);
        end
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    RESET = 1'b1;
    I_READ = 1'b0;
    I_ADDRESS = '0;
    D_READ = 1'b0;
    D_WRITE = 1'b0;
    D_ADDRESS = '0;
    D_WRITEDATA = '0;
    mem_lat = 1;
    addr_data = 1'b0;
    mem_pattern = '0;
    test_reset();
    test_i_read();
    test_priority();
    test_back_to_back();
    test_write();
    test_addr_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
